// File: rtl/reg_wb_arbiter.sv
// Register-file write-port arbiter: in-order writeback (port 0) shares WE3/A3/WD3
// with a multi-cycle unit (port 1) buffered in a 2-entry FIFO with anti-starvation.
module reg_wb_arbiter #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int STARVE_LIMIT  = 4
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic                          WB_EN0,
  input  logic [ADDRESS_WIDTH-1:0]      WB_RD0,
  input  logic [DATA_WIDTH-1:0]         WB_DATA0,
  output logic                          WB_STALL,
  input  logic                          MC_VALID,
  output logic                          MC_READY,
  input  logic [ADDRESS_WIDTH-1:0]      MC_RD,
  input  logic [DATA_WIDTH-1:0]         MC_DATA,
  output logic                          WE3,
  output logic [ADDRESS_WIDTH-1:0]      A3,
  output logic [DATA_WIDTH-1:0]         WD3,
  output logic [2**ADDRESS_WIDTH-1:0]   PENDING,
  output logic [1:0]                    BUF_COUNT
);

  localparam int NREG = 2**ADDRESS_WIDTH;

  // buffered port-1 writes; payload is never reset, only the live/pointer control is
  logic [ADDRESS_WIDTH-1:0] ent_rd   [2];
  logic [DATA_WIDTH-1:0]    ent_data [2];
  logic [1:0]               ent_live;
  logic                     wr_ptr;
  logic                     rd_ptr;
  logic [1:0]               count;
  logic [3:0]               starve;

  logic [1:0]               live_nxt;
  logic [1:0]               count_nxt;
  logic [3:0]               starve_nxt;
  logic                     p0_act;
  logic                     ready;
  logic                     accept;
  logic                     mc_keep;
  logic                     head_live;
  logic                     push;
  logic                     pop;
  logic                     kill_en;
  logic                     we;
  logic                     stall;
  logic [ADDRESS_WIDTH-1:0] a3;
  logic [DATA_WIDTH-1:0]    wd3;
  logic [NREG-1:0]          pend;

  always_comb begin
    we         = 1'b0;
    a3         = '0;
    wd3        = '0;
    stall      = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    kill_en    = 1'b0;
    starve_nxt = starve;
    p0_act     = WB_EN0 && (WB_RD0 != '0);
    // readiness is judged before any same-cycle pop
    ready      = RST_N && (count != 2'd2);
    accept     = MC_VALID && ready;
    mc_keep    = accept && (MC_RD != '0);
    head_live  = ent_live[rd_ptr];

    if (count == 2'd0) begin
      if (p0_act) begin
        we   = 1'b1;
        a3   = WB_RD0;
        wd3  = WB_DATA0;
        push = mc_keep;
      end else if (mc_keep) begin
        we  = 1'b1;
        a3  = MC_RD;
        wd3 = MC_DATA;
      end
    end else begin
      push = mc_keep;
      if (!head_live) begin
        // a superseded entry drains without touching the write port
        pop = 1'b1;
        if (p0_act) begin
          we      = 1'b1;
          a3      = WB_RD0;
          wd3     = WB_DATA0;
          kill_en = 1'b1;
        end
      end else if (!p0_act) begin
        we         = 1'b1;
        a3         = ent_rd[rd_ptr];
        wd3        = ent_data[rd_ptr];
        pop        = 1'b1;
        starve_nxt = '0;
      end else if (starve < 4'(STARVE_LIMIT)) begin
        we         = 1'b1;
        a3         = WB_RD0;
        wd3        = WB_DATA0;
        kill_en    = 1'b1;
        starve_nxt = starve + 4'd1;
      end else begin
        stall      = 1'b1;
        we         = 1'b1;
        a3         = ent_rd[rd_ptr];
        wd3        = ent_data[rd_ptr];
        pop        = 1'b1;
        starve_nxt = '0;
      end
    end

    count_nxt = count + {1'b0, push} - {1'b0, pop};
    if (count_nxt == 2'd0) starve_nxt = '0;
  end

  // port 0 is the newer value for its destination, so older buffered writes to it die
  always_comb begin
    live_nxt = ent_live;
    for (int i = 0; i < 2; i++) begin
      if (kill_en && ent_live[i] && (ent_rd[i] == WB_RD0)) live_nxt[i] = 1'b0;
    end
    if (pop)  live_nxt[rd_ptr] = 1'b0;
    if (push) live_nxt[wr_ptr] = 1'b1;
  end

  always_comb begin
    pend = '0;
    for (int i = 0; i < 2; i++) begin
      if (ent_live[i]) pend[ent_rd[i]] = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ent_live <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= '0;
      starve   <= '0;
    end else begin
      ent_live <= live_nxt;
      count    <= count_nxt;
      starve   <= starve_nxt;
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      ent_rd[wr_ptr]   <= MC_RD;
      ent_data[wr_ptr] <= MC_DATA;
    end
  end

  // combinational outputs are forced quiet while reset is held
  assign WE3       = RST_N && we;
  assign A3        = RST_N ? a3  : '0;
  assign WD3       = RST_N ? wd3 : '0;
  assign WB_STALL  = RST_N && stall;
  assign MC_READY  = ready;
  assign PENDING   = pend;
  assign BUF_COUNT = count;

endmodule
